// File: rtl/soc_system_gpio_pio.sv
// soc_system_gpio_pio: parametrised Avalon-MM GPIO slave.
// WIDTH-bit output register with atomic set/clear, a two-flop synchronised
// input with per-bit edge capture, an interrupt mask and a level irq.
// Optional per-bit debounce on the conditioned input: define GPIO_DEBOUNCE_EN.
`timescale 1ns/1ps
module soc_system_gpio_pio #(
  parameter int          WIDTH           = 8,
  parameter logic [31:0] OUT_RESET       = 32'h0000_0000,
  parameter int          EDGE_TYPE       = 0,
  parameter int          DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_OUT     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  logic [WIDTH-1:0] data_out_r;
  logic [WIDTH-1:0] irq_mask_r;
  logic [WIDTH-1:0] edge_cap_r;
  logic [WIDTH-1:0] s1_r;
  logic [WIDTH-1:0] s2_r;
  logic [WIDTH-1:0] s3_r;
  logic [1:0]       arm_r;
  logic [WIDTH-1:0] cond_s;
  logic [WIDTH-1:0] det_s;
  logic [WIDTH-1:0] w1c_s;
  logic [WIDTH-1:0] wd_s;
  logic             wr_s;
  logic             armed_s;
  logic             unused_wd_s;

  assign wr_s        = chipselect & ~write_n;
  assign wd_s        = writedata[WIDTH-1:0];
  assign unused_wd_s = ^writedata;
  assign armed_s     = (arm_r == 2'd3);

  // Two-flop synchroniser plus the previous-conditioned-value register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_r <= '0;
      s2_r <= '0;
      s3_r <= '0;
    end else begin
      s1_r <= in_port;
      s2_r <= s1_r;
      s3_r <= cond_s;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0]    db_cnt_r [WIDTH];
  logic [WIDTH-1:0] db_r;

  // Per-bit debounce: the counter runs only while s2 disagrees with db, so
  // any return to the debounced level restarts the count; db follows s2
  // after DEBOUNCE_CYCLES consecutive disagreeing clocks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_r <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        db_cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2_r[i] == db_r[i]) begin
          db_cnt_r[i] <= '0;
        end else if (db_cnt_r[i] == CNT_LAST) begin
          db_r[i]     <= s2_r[i];
          db_cnt_r[i] <= '0;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + CW'(1);
        end
      end
    end
  end

  assign cond_s = db_r;
`else
  assign cond_s = s2_r;
`endif

  // Arm counter: holds off edge detection until the pipeline holds real data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_r <= 2'd0;
    end else if (!armed_s) begin
      arm_r <= arm_r + 2'd1;
    end else begin
      arm_r <= arm_r;
    end
  end

  // Edge detector selected by EDGE_TYPE, gated by the arm state.
  always_comb begin
    det_s = '0;
    if (armed_s) begin
      case (EDGE_TYPE)
        0:       det_s = cond_s & ~s3_r;
        1:       det_s = ~cond_s & s3_r;
        2:       det_s = cond_s ^ s3_r;
        default: det_s = cond_s & ~s3_r;
      endcase
    end else begin
      det_s = '0;
    end
  end

  // Write-1-to-clear mask for the edge capture register.
  always_comb begin
    w1c_s = '0;
    if (wr_s && (address == ADDR_EDGECAP)) begin
      w1c_s = wd_s;
    end else begin
      w1c_s = '0;
    end
  end

  // Edge capture: a newly detected edge wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cap_r <= '0;
    end else begin
      edge_cap_r <= (edge_cap_r & ~w1c_s) | det_s;
    end
  end

  // Output data register with plain load, atomic set and atomic clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_r <= OUT_RESET[WIDTH-1:0];
    end else if (wr_s) begin
      case (address)
        ADDR_DATA, ADDR_OUT: data_out_r <= wd_s;
        ADDR_OUTSET:         data_out_r <= data_out_r | wd_s;
        ADDR_OUTCLR:         data_out_r <= data_out_r & ~wd_s;
        default:             data_out_r <= data_out_r;
      endcase
    end else begin
      data_out_r <= data_out_r;
    end
  end

  // Interrupt mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask_r <= '0;
    end else if (wr_s && (address == ADDR_IRQMASK)) begin
      irq_mask_r <= wd_s;
    end else begin
      irq_mask_r <= irq_mask_r;
    end
  end

  // Zero-wait-state read mux; unused upper bits stay zero.
  always_comb begin
    readdata = 32'h0000_0000;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = cond_s;
      ADDR_OUT:     readdata[WIDTH-1:0] = data_out_r;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = irq_mask_r;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = edge_cap_r;
      default:      readdata = 32'h0000_0000;
    endcase
  end

  assign out_port = data_out_r;
  assign irq      = |(edge_cap_r & irq_mask_r);

endmodule
